// File: rtl/time_base_gen_if.sv
// Control and status bundle of the time-base generator: run/clear/load
// controls in, tick strobes, square waves and time-of-day out.
interface time_base_gen_if;
    logic       en;
    logic       sclr;
    logic       ld;
    logic [4:0] ld_hour;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic       tick_us;
    logic       tick_ms;
    logic       tick_s;
    logic       tick_m;
    logic       tick_h;
    logic       tick_d;
    logic       sq_ms;
    logic       sq_s;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;

    modport master (
        output en, sclr, ld, ld_hour, ld_min, ld_sec,
        input  tick_us, tick_ms, tick_s, tick_m, tick_h, tick_d,
        input  sq_ms, sq_s, hour, min, sec
    );

    modport slave (
        input  en, sclr, ld, ld_hour, ld_min, ld_sec,
        output tick_us, tick_ms, tick_s, tick_m, tick_h, tick_d,
        output sq_ms, sq_s, hour, min, sec
    );
endinterface

// File: rtl/time_base_gen.sv
// Cascaded time-base generator: clk -> us -> ms -> s -> min -> h -> day
// single-cycle tick strobes, ms/s square waves and a loadable time of day.
module time_base_gen #(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned US_PER_MS  = 1000,
    parameter int unsigned MS_PER_S   = 1000
) (
    input  logic           clk,
    input  logic           x_clr,
    time_base_gen_if.slave bus
);
    localparam int unsigned CW = $clog2(CLK_PER_US);
    localparam int unsigned UW = $clog2(US_PER_MS);
    localparam int unsigned MW = $clog2(MS_PER_S);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLK_PER_US - 1);
    localparam logic [UW-1:0] US_LAST  = UW'(US_PER_MS - 1);
    localparam logic [MW-1:0] MS_LAST  = MW'(MS_PER_S - 1);
    localparam logic [UW-1:0] US_HALF  = UW'(US_PER_MS / 2);
    localparam logic [MW-1:0] MS_HALF  = MW'(MS_PER_S / 2);

    logic [CW-1:0] c_clk, c_clk_nx;
    logic [UW-1:0] c_us,  c_us_nx;
    logic [MW-1:0] c_ms,  c_ms_nx;
    logic [5:0]    sec_nx, min_nx;
    logic [4:0]    hour_nx;
    logic          c0, c1, c2, c3, c4, c5;
    logic [5:0]    tick_nx;
    logic          sq_ms_nx, sq_s_nx;

    always_comb begin
        c0 = (c_clk == CLK_LAST);
        c1 = c0 && (c_us == US_LAST);
        c2 = c1 && (c_ms == MS_LAST);
        c3 = c2 && (bus.sec == 6'd59);
        c4 = c3 && (bus.min == 6'd59);
        c5 = c4 && (bus.hour == 5'd23);
    end

    always_comb begin
        c_clk_nx = c_clk;
        c_us_nx  = c_us;
        c_ms_nx  = c_ms;
        sec_nx   = bus.sec;
        min_nx   = bus.min;
        hour_nx  = bus.hour;
        tick_nx  = '0;
        if (bus.sclr) begin
            c_clk_nx = '0;
            c_us_nx  = '0;
            c_ms_nx  = '0;
            sec_nx   = '0;
            min_nx   = '0;
            hour_nx  = '0;
        end else if (bus.ld) begin
            c_clk_nx = '0;
            c_us_nx  = '0;
            c_ms_nx  = '0;
            sec_nx   = (bus.ld_sec  < 6'd60) ? bus.ld_sec  : '0;
            min_nx   = (bus.ld_min  < 6'd60) ? bus.ld_min  : '0;
            hour_nx  = (bus.ld_hour < 5'd24) ? bus.ld_hour : '0;
        end else if (bus.en) begin
            c_clk_nx = c0 ? '0 : c_clk + 1'b1;
            if (c0) c_us_nx  = c1 ? '0 : c_us + 1'b1;
            if (c1) c_ms_nx  = c2 ? '0 : c_ms + 1'b1;
            if (c2) sec_nx   = c3 ? '0 : bus.sec + 1'b1;
            if (c3) min_nx   = c4 ? '0 : bus.min + 1'b1;
            if (c4) hour_nx  = c5 ? '0 : bus.hour + 1'b1;
            tick_nx = {c5, c4, c3, c2, c1, c0};
        end
        // Clear/load zero the sub-second counts and hold keeps them, so
        // deriving the squares from the next counts covers every case.
        sq_ms_nx = (c_us_nx >= US_HALF);
        sq_s_nx  = (c_ms_nx >= MS_HALF);
    end

    always_ff @(posedge clk or negedge x_clr) begin
        if (!x_clr) begin
            c_clk       <= '0;
            c_us        <= '0;
            c_ms        <= '0;
            bus.sec     <= '0;
            bus.min     <= '0;
            bus.hour    <= '0;
            bus.tick_us <= 1'b0;
            bus.tick_ms <= 1'b0;
            bus.tick_s  <= 1'b0;
            bus.tick_m  <= 1'b0;
            bus.tick_h  <= 1'b0;
            bus.tick_d  <= 1'b0;
            bus.sq_ms   <= 1'b0;
            bus.sq_s    <= 1'b0;
        end else begin
            c_clk       <= c_clk_nx;
            c_us        <= c_us_nx;
            c_ms        <= c_ms_nx;
            bus.sec     <= sec_nx;
            bus.min     <= min_nx;
            bus.hour    <= hour_nx;
            bus.tick_us <= tick_nx[0];
            bus.tick_ms <= tick_nx[1];
            bus.tick_s  <= tick_nx[2];
            bus.tick_m  <= tick_nx[3];
            bus.tick_h  <= tick_nx[4];
            bus.tick_d  <= tick_nx[5];
            bus.sq_ms   <= sq_ms_nx;
            bus.sq_s    <= sq_s_nx;
        end
    end
endmodule
